// File: rtl/fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// fp_div_arbiter : round-robin front end sharing one FP divider between two
//                  requesters. Define FPDIV_ARB_TIMEOUT_EN for a WAIT watchdog.
// Revision       : 1.0 - initial release
// ============================================================================
module fp_div_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid0,
  input  logic             req_valid1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             req_ready0,
  output logic             req_ready1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  output logic [WIDTH-1:0] resp_q,
  output logic             resp_ovf,
  output logic             resp_unf,
  output logic             resp_err,
  input  logic             resp_ready0,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_start,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_ovf,
  input  logic             div_unf,
  input  logic             div_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             start_q, start_d;
  logic             rv0_q, rv0_d, rv1_q, rv1_d;
  logic             grant0, grant1;

`ifdef FPDIV_ARB_TIMEOUT_EN
  localparam int               CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WIDTH-1:0] TO_Q = WIDTH'(32'h7FC0_0000);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign resp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign resp_err       = 1'b0;
`endif

  // A tie goes to the requester that was not served last.
  assign grant0 = req_valid0 && (!req_valid1 || last_q);
  assign grant1 = req_valid1 && (!req_valid0 || !last_q);

  assign req_ready0   = (state_q == IDLE) && grant0;
  assign req_ready1   = (state_q == IDLE) && grant1;
  assign resp_valid0  = rv0_q;
  assign resp_valid1  = rv1_q;
  assign resp_q       = quo_q;
  assign resp_ovf     = ovf_q;
  assign resp_unf     = unf_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign div_start    = start_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    start_d = 1'b0;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
`ifdef FPDIV_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          gnt_d   = grant1;
          a_d     = grant1 ? req_a1 : req_a0;
          b_d     = grant1 ? req_b1 : req_b0;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FPDIV_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (div_ready) begin
          quo_d   = div_quotient;
          ovf_d   = div_ovf;
          unf_d   = div_unf;
          rv0_d   = !gnt_q;
          rv1_d   = gnt_q;
          state_d = RESP;
`ifdef FPDIV_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          quo_d   = TO_Q;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          err_d   = 1'b1;
          rv0_d   = !gnt_q;
          rv1_d   = gnt_q;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        if (gnt_q ? resp_ready1 : resp_ready0) begin
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      start_q <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      start_q <= start_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
`ifdef FPDIV_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fp_div_arbiter : self-checking bench with a latency-programmable divider
//                     model and a response scoreboard.
// Revision          : 1.0 - initial release
// ============================================================================
module tb_fp_div_arbiter;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic        req_ready0, req_ready1, resp_valid0, resp_valid1;
  logic [31:0] resp_q;
  logic        resp_ovf, resp_unf, resp_err;
  logic        resp_ready0 = 1'b1, resp_ready1 = 1'b1;
  logic [31:0] div_dividend, div_divisor, div_quotient;
  logic        div_start, div_ovf, div_unf, div_ready;

  fp_div_arbiter #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clr(clr),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_q(resp_q), .resp_ovf(resp_ovf), .resp_unf(resp_unf), .resp_err(resp_err),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
    .div_quotient(div_quotient), .div_ovf(div_ovf), .div_unf(div_unf),
    .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endfunction

  // Stand-in for the external divider: a fixed quotient for the reference
  // operand pair, otherwise an operand-dependent pattern.
  function automatic logic [31:0] dfn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40F8_0000 && b == 32'hC040_0000) return 32'hC025_5555;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  int          lat       = 4;
  bit          never_rdy = 1'b0;
  bit          mdl_ovf   = 1'b0, mdl_unf = 1'b0;
  bit          exp_to    = 1'b0;
  logic        stray     = 1'b0;
  int          dcnt      = 0;
  logic        mdl_rdy   = 1'b0;
  logic [31:0] mdl_q     = '0;
  logic        mdl_o     = 1'b0, mdl_u = 1'b0;

  always @(posedge clk) begin
    mdl_rdy <= 1'b0;
    if (div_start && !never_rdy) begin
      mdl_q <= dfn(div_dividend, div_divisor);
      mdl_o <= mdl_ovf;
      mdl_u <= mdl_unf;
      dcnt  <= lat - 1;
      if (lat == 1) mdl_rdy <= 1'b1;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) mdl_rdy <= 1'b1;
    end
  end

  assign div_ready    = mdl_rdy | stray;
  assign div_quotient = mdl_q;
  assign div_ovf      = mdl_o;
  assign div_unf      = mdl_u;

  typedef struct {
    logic        idx;
    logic [31:0] q;
    logic        ovf, unf, err;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (clr) sb.delete();
    else begin
      if (req_valid0 && req_ready0)
        sb.push_back('{1'b0, exp_to ? 32'h7FC0_0000 : dfn(req_a0, req_b0),
                       exp_to ? 1'b0 : mdl_ovf, exp_to ? 1'b0 : mdl_unf, exp_to});
      if (req_valid1 && req_ready1)
        sb.push_back('{1'b1, exp_to ? 32'h7FC0_0000 : dfn(req_a1, req_b1),
                       exp_to ? 1'b0 : mdl_ovf, exp_to ? 1'b0 : mdl_unf, exp_to});
      if ((resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1)) begin
        if (sb.size() == 0) check("sb_unexpected_resp", 1, 0);
        else begin
          e = sb.pop_front();
          check("sb_idx", {resp_valid1, resp_valid0}, e.idx ? 2'b10 : 2'b01);
          check("sb_q", resp_q, e.q);
          check("sb_flags", {resp_ovf, resp_unf, resp_err}, {e.ovf, e.unf, e.err});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int k);
    case (k)
      0:       return div_start;
      1:       return resp_valid0;
      2:       return resp_valid1;
      default: return req_ready0 | req_ready1;
    endcase
  endfunction

  task automatic wait_for(input int k, input int lim, input string nm);
    int n = 0;
    @(negedge clk);
    while (sig(k) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, sig(k), 1);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_valid", {resp_valid1, resp_valid0, div_start}, 0);
    check("rst_q", resp_q, 0);
    check("rst_flags", {resp_ovf, resp_unf, resp_err}, 0);
    cyc();
    clr = 1'b0;
  endtask

  typedef struct {
    bit          v0, v1;
    logic [31:0] a0, b0, a1, b1;
    bit          ovf, unf;
    int          lat;
    bit          g;
  } vec_t;

  vec_t vt[8];
  int   t0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 0, 0, 3, 0};
    vt[1] = '{1, 1, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 0, 0, 5, 1};
    vt[2] = '{1, 1, 32'hC120_0000, 32'h4120_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 2, 0};
    vt[3] = '{1, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 6, 1};
    vt[4] = '{0, 1, 32'h0, 32'h0, 32'h7F7F_FFFF, 32'h0080_0000, 1, 0, 4, 1};
    vt[5] = '{1, 0, 32'h0080_0000, 32'h7F7F_FFFF, 32'h0, 32'h0, 0, 1, 4, 0};
    vt[6] = '{1, 1, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0F0F_F0F0, 32'hF0F0_0F0F, 0, 0, 3, 1};
    vt[7] = '{1, 0, 32'h7F00_0000, 32'h0000_0002, 32'h0, 32'h0, 1, 1, 2, 0};

    // Reference single request with divider latency 24.
    do_reset();
    cyc();
    lat = 24;
    req_valid0 = 1'b1; req_a0 = 32'h40F8_0000; req_b0 = 32'hC040_0000;
    wait_for(3, 5, "ref_accept");
    check("ref_grant", {req_ready1, req_ready0}, 2'b01);
    t0 = cyc_n;
    cyc();
    req_valid0 = 1'b0;
    wait_for(0, 5, "ref_start");
    check("ref_start_lat", cyc_n - t0, 1);
    wait_for(1, 60, "ref_resp");
    check("ref_resp_lat", cyc_n - t0, 26);
    check("ref_q", resp_q, 32'hC025_5555);
    check("ref_flags", {resp_ovf, resp_unf, resp_err}, 0);

    // A div_ready outside WAIT must not produce a response.
    cyc();
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_ignored", {resp_valid1, resp_valid0, resp_q}, {2'b00, 32'hC025_5555});
      cyc();
    end

    // Table of arbitration/flag vectors starting from a fresh pointer.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc();
      lat = vt[i].lat; mdl_ovf = vt[i].ovf; mdl_unf = vt[i].unf;
      req_valid0 = vt[i].v0; req_a0 = vt[i].a0; req_b0 = vt[i].b0;
      req_valid1 = vt[i].v1; req_a1 = vt[i].a1; req_b1 = vt[i].b1;
      wait_for(3, 5, $sformatf("vec%0d_accept", i));
      check($sformatf("vec%0d_grant", i), {req_ready1, req_ready0}, vt[i].g ? 2'b10 : 2'b01);
      cyc();
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      wait_for(vt[i].g ? 2 : 1, 40, $sformatf("vec%0d_resp", i));
      check($sformatf("vec%0d_other_idle", i), vt[i].g ? resp_valid0 : resp_valid1, 0);
    end
    mdl_ovf = 1'b0; mdl_unf = 1'b0;

    // Response backpressure on requester 0 while requester 1 waits.
    cyc();
    resp_ready0 = 1'b0; lat = 3;
    req_valid0 = 1'b1; req_a0 = 32'h4110_0000; req_b0 = 32'h4040_0000;
    wait_for(3, 5, "bp_accept");
    cyc();
    req_valid0 = 1'b0;
    req_valid1 = 1'b1; req_a1 = 32'h4248_0000; req_b1 = 32'h40A0_0000;
    wait_for(1, 20, "bp_resp");
    repeat (10) begin
      cyc();
      @(negedge clk);
      check("bp_hold", {resp_valid0, req_ready1, div_start, resp_valid1}, 4'b1000);
    end
    cyc();
    resp_ready0 = 1'b1;
    cyc();
    @(negedge clk);
    check("bp_next_grant", {req_ready1, req_ready0}, 2'b10);
    cyc();
    req_valid1 = 1'b0;
    wait_for(2, 20, "bp_r1_resp");

    // Reset in WAIT abandons the operation; the late div_ready is ignored.
    cyc();
    lat = 7;
    req_valid0 = 1'b1; req_a0 = 32'h4000_0000; req_b0 = 32'h3F00_0000;
    wait_for(3, 5, "clr_accept");
    cyc();
    req_valid0 = 1'b0;
    wait_for(0, 5, "clr_start");
    repeat (3) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("clr_no_resp", {resp_valid1, resp_valid0}, 0);
      cyc();
    end
    lat = 5;
    req_valid1 = 1'b1; req_a1 = 32'h4080_0000; req_b1 = 32'h4000_0000;
    wait_for(3, 5, "post_clr_accept");
    cyc();
    req_valid1 = 1'b0;
    wait_for(2, 20, "post_clr_resp");

`ifdef FPDIV_ARB_TIMEOUT_EN
    // Divider never answers: the watchdog produces an error response.
    cyc();
    never_rdy = 1'b1; exp_to = 1'b1;
    req_valid0 = 1'b1; req_a0 = 32'h3F80_0000; req_b0 = 32'h0000_0000;
    wait_for(3, 5, "to_accept");
    t0 = cyc_n;
    cyc();
    req_valid0 = 1'b0;
    wait_for(1, TO + 20, "to_resp");
    check("to_lat", cyc_n - t0, TO + 2);
    check("to_q", resp_q, 32'h7FC0_0000);
    check("to_flags", {resp_ovf, resp_unf, resp_err}, 3'b001);
    cyc();
    never_rdy = 1'b0; exp_to = 1'b0;
`endif

    repeat (3) cyc();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/quotient width (IEEE-754 single).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, divider watchdog limit (used only when FPDIV_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req_valid0/req_valid1, input, 1 each, requester has an operation pending.
REQ-006 SHALL have ports req_a0/req_a1 and req_b0/req_b1, input, WIDTH each, dividend and divisor.
REQ-007 SHALL have ports req_ready0/req_ready1, output, 1 each, operation accepted this cycle.
REQ-008 SHALL have ports resp_valid0/resp_valid1, output, 1 each, result available.
REQ-009 SHALL have ports resp_q, output, WIDTH; resp_ovf, resp_unf, resp_err, output, 1 each; shared by both requesters and qualified by resp_validN.
REQ-010 SHALL have ports resp_ready0/resp_ready1, input, 1 each, requester consumes the result.
REQ-011 SHALL have ports div_dividend/div_divisor, output, WIDTH, and div_start, output, 1, which drive the shared divider.
REQ-012 SHALL have ports div_quotient, input, WIDTH; div_ovf, div_unf, div_ready, input, 1 each, returned by the divider.

Function
REQ-013 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-014 In IDLE, with any req_validN high, SHALL grant a single requester by round-robin: when both are valid, the requester not last served wins.
REQ-015 In the IDLE cycle where it grants, SHALL assert req_readyN combinationally for the granted requester only, latch its a/b operands and grant index, and move to ISSUE.
REQ-016 req_readyN SHALL be 0 in every state other than IDLE.
REQ-017 In ISSUE, SHALL drive div_start=1 for exactly one cycle and then move to WAIT.
REQ-018 div_dividend/div_divisor SHALL hold the latched operands, stable, from ISSUE through RESP.
REQ-019 div_ready SHALL be sampled only in WAIT; a div_ready in any other state SHALL be ignored.
REQ-020 In WAIT, on div_ready=1, SHALL latch div_quotient, div_ovf and div_unf unchanged into resp_q/resp_ovf/resp_unf, set resp_err=0, and move to RESP.
REQ-021 In RESP, SHALL hold resp_validN=1 for the granted requester until resp_readyN=1 in that same cycle.
REQ-022 On that RESP handshake, SHALL update the last-served pointer to the granted requester and return to IDLE; a new grant is possible no earlier than the following cycle.
REQ-023 resp_readyN from the non-granted requester SHALL have no effect.
REQ-024 Latency: accept at cycle T, div_start at T+1, divider done at T+1+N, resp_valid from T+2+N.
REQ-025 Req_valid dropped before acceptance SHALL be allowed; the arbiter makes no request-hold assumption.

Reset
REQ-026 When clr=1 at a rising edge, SHALL enter IDLE with the last-served pointer set to requester 1, so requester 0 wins the first tie.
REQ-027 clr SHALL clear div_start, resp_valid0/1, resp_q, resp_ovf, resp_unf and resp_err to 0.
REQ-028 clr asserted mid-operation (ISSUE, WAIT or RESP) SHALL abandon the operation without a response.
REQ-029 A late div_ready following a mid-operation reset SHALL be ignored.

Configuration
REQ-030 With macro FPDIV_ARB_TIMEOUT_EN defined, SHALL count cycles in WAIT; reaching TIMEOUT_CYCLES without div_ready SHALL enter RESP with resp_q=32'h7FC00000, resp_err=1, resp_ovf=0 and resp_unf=0.
REQ-031 With FPDIV_ARB_TIMEOUT_EN defined, the WAIT cycle counter SHALL clear on entry to WAIT and on clr.
REQ-032 With FPDIV_ARB_TIMEOUT_EN undefined, SHALL contain no counter, tie resp_err to 0, and remain in WAIT indefinitely until div_ready.

Verification
REQ-033 Single request: req_valid0 with a=32'h40F80000 (7.75) and b=32'hC0400000 (-3.0), divider model latency 24 -> div_start at T+1, resp_valid0 at T+26, resp_q equals the model quotient (32'hC0255555 truncated), ovf=unf=err=0.
REQ-034 Simultaneous requests after reset: both valid -> grants in the order 0,1,0,1, with no starvation across 4 back-to-back ops.
REQ-035 Response backpressure: hold resp_ready0=0 for 10 cycles -> resp_valid0 stays 1, req_ready1 stays 0 and no div_start is issued until the handshake.
REQ-036 clr during WAIT, then a div_ready pulse 3 cycles later -> no resp_valid; the next request completes normally.
REQ-037 FPDIV_ARB_TIMEOUT_EN defined with a divider that never asserts ready -> resp_err=1 and resp_q=32'h7FC00000 exactly TIMEOUT_CYCLES cycles after entering WAIT.
REQ-038 Propagate the divider's overflow (div_ovf=1) and underflow (div_unf=1) cases -> each flag appears on resp_ovf/resp_unf for the granted requester only.
